check_axis_packet: RTL and testbench
====================================

// Module: check_axis_packet
// PURPOSE
// - Receive-side checker for fixed-length AXI-Stream packets (header + NUM_DATA_WORDS data words) from links such as writeFMPSTestLink.
// - Checks header magic and packet length, extracts index and payload, reports one status per packet and flags FA cycles with no packet.
// - Drives TREADY with a pseudo-random duty cycle to stress sender back-pressure. Runs entirely in the Aurora user clock domain.
// PARAMETERS
// - MAGIC_WIDTH      16   width of header magic field
// - MAGIC_START_BIT  16   LSB position of magic in header word
// - INDEX_WIDTH      5    width of header index field
// - INDEX_START_BIT  10   LSB position of index in header word
// - NUM_DATA_WORDS   1    32-bit data words following header (>=1)
// - TREADY_PROB      0.5  real, TREADY high probability; THRESH=floor(TREADY_PROB*65536) at elaboration; >=1.0 means TREADY always 1
// PORTS
// - auroraClk            in   1                 clock; the only clock, all logic on rising edge
// - auroraReset          in   1                 synchronous, active-high reset
// - newCycleStrobe       in   1                 one-cycle pulse marking each FA cycle boundary
// - TVALID               in   1                 AXIS valid
// - TLAST                in   1                 AXIS last
// - TDATA                in   32                AXIS data
// - TREADY               out  1                 AXIS ready (registered)
// - expectedHeaderMagic  in   MAGIC_WIDTH       required magic value, e.g. 16'hB6CF
// - statusStrobe         out  1                 one-cycle pulse, statusCode valid
// - statusCode           out  2                 0 OK, 1 bad magic, 2 bad length, 3 missing packet
// - packetStrobe         out  1                 one-cycle pulse on each good packet
// - packetIndex          out  INDEX_WIDTH       header index of last good packet
// - packetData           out  32*NUM_DATA_WORDS data; data word k in bits [32k+31:32k]
// BEHAVIOUR
// - Reset: all outputs 0, TREADY 0, state HEADER, word counter 0, LFSR=16'hACE1, gotPacket=0, armed=0.
// - Beat = TVALID & TREADY on a rising edge; no other TDATA/TLAST sampling.
// - TREADY: 16-bit Fibonacci LFSR x^16+x^14+x^13+x^11+1 steps every cycle; TREADY <= (lfsr < THRESH) out of reset.
// - State HEADER: on beat capture index=TDATA[INDEX_START_BIT+:INDEX_WIDTH] and compare TDATA[MAGIC_START_BIT+:MAGIC_WIDTH] to expectedHeaderMagic.
//   - magic mismatch: if TLAST, report 1 now, stay HEADER; else go DISCARD with pending code 1 (magic has priority over length).
//   - magic ok & TLAST: report 2, stay HEADER.  magic ok & !TLAST: go DATA, counter=0.
// - State DATA: on beat store TDATA into data word[counter].
//   - counter<NUM_DATA_WORDS-1 & TLAST: report 2, go HEADER.
//   - counter==NUM_DATA_WORDS-1 & TLAST: report 0, packetStrobe, update packetIndex/packetData, go HEADER.
//   - counter==NUM_DATA_WORDS-1 & !TLAST: go DISCARD with pending code 2.
// - State DISCARD: drop beats; on TLAST beat report pending code, go HEADER.
// - Report = statusStrobe/statusCode (and packetStrobe for code 0) asserted on the cycle after the triggering beat; strobes 1 cycle wide.
// - packetIndex/packetData change only on good packets and hold otherwise; partial data from bad packets never reaches outputs.
// - Any completed packet (any code) sets gotPacket.
// - newCycleStrobe: first one after reset only sets armed. Later ones: if !gotPacket and no packet completes this cycle, report 3; clear gotPacket.
// - Simultaneous packet completion and newCycleStrobe: only the packet status is reported and it counts for the ending cycle; gotPacket cleared.
// - Packet in flight at newCycleStrobe is unaffected and counts toward the next cycle.
// - Reset mid-packet: abandon packet, no status, return to reset state.
// TESTING
// - TREADY_PROB=1.0, header 32'hB6CF_0400 then 32'h1234_5678+TLAST -> packetStrobe, packetIndex=1, packetData=32'h12345678, statusCode=0, 1 cycle after last beat.
// - Header 32'hDEAD_0400, data+TLAST -> statusCode=1, no packetStrobe, packetIndex/packetData keep previous values.
// - Header 32'hB6CF_0800 with TLAST -> statusCode=2; 3-word packet, last with TLAST -> code 2 once, at the TLAST beat.
// - Two newCycleStrobes 201 cycles apart with no packet -> first ignored, second gives statusCode=3; TLAST beat coinciding with strobe -> code 0 only.
// - TREADY_PROB=0.5 over 10000 cycles -> TREADY high 45-55%; sender holding TVALID yields identical results to TREADY=1.
// - Assert auroraReset during DATA state -> no status, next clean packet checked normally.

Source files
------------

// File: rtl/check_axis_packet.sv
// Receive-side checker for fixed-length AXI-Stream packets (header + NUM_DATA_WORDS
// data words) in the Aurora user clock domain, with pseudo-random TREADY back-pressure.
module check_axis_packet #(
    parameter int  MAGIC_WIDTH     = 16,
    parameter int  MAGIC_START_BIT = 16,
    parameter int  INDEX_WIDTH     = 5,
    parameter int  INDEX_START_BIT = 10,
    parameter int  NUM_DATA_WORDS  = 1,
    parameter real TREADY_PROB     = 0.5
) (
    input  logic                          auroraClk,
    input  logic                          auroraReset,
    input  logic                          newCycleStrobe,
    input  logic                          TVALID,
    input  logic                          TLAST,
    input  logic [31:0]                   TDATA,
    output logic                          TREADY,
    input  logic [MAGIC_WIDTH-1:0]        expectedHeaderMagic,
    output logic                          statusStrobe,
    output logic [1:0]                    statusCode,
    output logic                          packetStrobe,
    output logic [INDEX_WIDTH-1:0]        packetIndex,
    output logic [32*NUM_DATA_WORDS-1:0]  packetData,
    output logic [1:0]                    debugState
);

    // Handshake: a beat is TVALID & TREADY at a rising edge of auroraClk. TDATA and
    // TLAST are looked at only on beats, and TREADY never depends on TVALID.

    localparam int CNT_W  = (NUM_DATA_WORDS > 1) ? $clog2(NUM_DATA_WORDS) : 1;
    localparam int THRESH = (TREADY_PROB >= 1.0) ? 65536 :
                            (TREADY_PROB <= 0.0) ? 0 : $rtoi(TREADY_PROB * 65536.0);
    localparam logic [16:0]      THRESH_V = 17'(THRESH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DATA_WORDS - 1);

    localparam logic [1:0] CODE_OK      = 2'd0;
    localparam logic [1:0] CODE_MAGIC   = 2'd1;
    localparam logic [1:0] CODE_LENGTH  = 2'd2;
    localparam logic [1:0] CODE_MISSING = 2'd3;

    typedef enum logic [1:0] {
        stHeader  = 2'd0,
        stData    = 2'd1,
        stDiscard = 2'd2
    } state_t;

    state_t                        state;
    logic [CNT_W-1:0]              wordCnt;
    logic [15:0]                   lfsr;
    logic [1:0]                    pendCode;
    logic                          gotPacket;
    logic                          armed;
    logic [INDEX_WIDTH-1:0]        hdrIndex;
    logic [32*NUM_DATA_WORDS-1:0]  dataBuf;
    logic [32*NUM_DATA_WORDS-1:0]  assembled;
    logic                          beat;
    logic                          magicOk;
    logic                          lastWord;
    logic                          lfsrFb;
    logic                          pktDone;
    logic                          missing;
    logic [1:0]                    pktCode;

    assign beat       = TVALID & TREADY;
    assign magicOk    = (TDATA[MAGIC_START_BIT +: MAGIC_WIDTH] == expectedHeaderMagic);
    assign lastWord   = (wordCnt == LAST_CNT);
    assign lfsrFb     = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
    assign missing    = newCycleStrobe & armed & ~gotPacket & ~pktDone;
    assign debugState = state;

    // Data words as they would look once the current beat is stored.
    always_comb begin
        assembled = dataBuf;
        assembled[32*int'(wordCnt) +: 32] = TDATA;
    end

    // A packet completes on any TLAST beat; the code depends on where it ended.
    always_comb begin
        pktDone = 1'b0;
        pktCode = CODE_OK;
        if (beat && TLAST) begin
            pktDone = 1'b1;
            case (state)
                stHeader: pktCode = magicOk ? CODE_LENGTH : CODE_MAGIC;
                stData:   pktCode = lastWord ? CODE_OK : CODE_LENGTH;
                default:  pktCode = pendCode;
            endcase
        end
    end

    always_ff @(posedge auroraClk) begin
        if (auroraReset) begin
            state        <= stHeader;
            wordCnt      <= '0;
            lfsr         <= 16'hACE1;
            TREADY       <= 1'b0;
            pendCode     <= CODE_OK;
            gotPacket    <= 1'b0;
            armed        <= 1'b0;
            hdrIndex     <= '0;
            dataBuf      <= '0;
            statusStrobe <= 1'b0;
            statusCode   <= CODE_OK;
            packetStrobe <= 1'b0;
            packetIndex  <= '0;
            packetData   <= '0;
        end else begin
            lfsr         <= {lfsrFb, lfsr[15:1]};
            TREADY       <= ({1'b0, lfsr} < THRESH_V);
            statusStrobe <= 1'b0;
            packetStrobe <= 1'b0;

            // A packet finishing on the strobe cycle wins over a missing report.
            if (pktDone) begin
                statusStrobe <= 1'b1;
                statusCode   <= pktCode;
                if (pktCode == CODE_OK) begin
                    packetStrobe <= 1'b1;
                    packetIndex  <= hdrIndex;
                    packetData   <= assembled;
                end
            end else if (missing) begin
                statusStrobe <= 1'b1;
                statusCode   <= CODE_MISSING;
            end

            if (newCycleStrobe) begin
                armed <= 1'b1;
            end
            if (newCycleStrobe && armed) begin
                gotPacket <= 1'b0;
            end else if (pktDone) begin
                gotPacket <= 1'b1;
            end

            case (state)
                stHeader: begin
                    if (beat) begin
                        hdrIndex <= TDATA[INDEX_START_BIT +: INDEX_WIDTH];
                        if (!TLAST) begin
                            if (!magicOk) begin
                                state    <= stDiscard;
                                pendCode <= CODE_MAGIC;
                            end else begin
                                state   <= stData;
                                wordCnt <= '0;
                            end
                        end
                    end
                end
                stData: begin
                    if (beat) begin
                        dataBuf <= assembled;
                        if (TLAST) begin
                            state <= stHeader;
                        end else if (lastWord) begin
                            state    <= stDiscard;
                            pendCode <= CODE_LENGTH;
                        end else begin
                            wordCnt <= wordCnt + CNT_W'(1);
                        end
                    end
                end
                stDiscard: begin
                    if (beat && TLAST) begin
                        state <= stHeader;
                    end
                end
                default: state <= stHeader;
            endcase
        end
    end

endmodule

// File: tb/tb_check_axis_packet.sv
// Bench for check_axis_packet: one instance with TREADY always high, one with 50% TREADY.
module tb_check_axis_packet;
    localparam int          N     = 1;
    localparam int          W     = 40;
    localparam logic [15:0] MAGIC = 16'hB6CF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ncs;
    logic        ncs_b;
    logic        tv    [2];
    logic        tl    [2];
    logic [31:0] td    [2];
    logic        rdy   [2];
    logic        sstb  [2];
    logic [1:0]  scode [2];
    logic        pstb  [2];
    logic [4:0]  pidx  [2];
    logic [31:0] pdat  [2];
    logic [1:0]  dbg   [2];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: held outputs of the last good packet, per instance.
    logic [4:0]   held_idx [2];
    logic [31:0]  held_dat [2];
    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    logic [31:0]  pkt_w[$];

    check_axis_packet #(.NUM_DATA_WORDS(N), .TREADY_PROB(1.0)) dut_a (
        .auroraClk(clk), .auroraReset(rst), .newCycleStrobe(ncs),
        .TVALID(tv[0]), .TLAST(tl[0]), .TDATA(td[0]), .TREADY(rdy[0]),
        .expectedHeaderMagic(MAGIC),
        .statusStrobe(sstb[0]), .statusCode(scode[0]), .packetStrobe(pstb[0]),
        .packetIndex(pidx[0]), .packetData(pdat[0]), .debugState(dbg[0])
    );

    check_axis_packet #(.NUM_DATA_WORDS(N), .TREADY_PROB(0.5)) dut_b (
        .auroraClk(clk), .auroraReset(rst), .newCycleStrobe(ncs_b),
        .TVALID(tv[1]), .TLAST(tl[1]), .TDATA(td[1]), .TREADY(rdy[1]),
        .expectedHeaderMagic(MAGIC),
        .statusStrobe(sstb[1]), .statusCode(scode[1]), .packetStrobe(pstb[1]),
        .packetIndex(pidx[1]), .packetData(pdat[1]), .debugState(dbg[1])
    );

    // Scoreboard: every observed status must match the head of the expected queue.
    logic [W-1:0] mon_g_a, mon_e_a, mon_g_b, mon_e_b;
    always @(negedge clk) begin
        if (!rst) begin
            if (sstb[0] || pstb[0]) begin
                mon_g_a = {scode[0], pstb[0], pidx[0], pdat[0]};
                n_checks++;
                if (exp_a.size() == 0) begin
                    $display("FAIL dut0_unexpected_status got code=%0d pstb=%0d required no status",
                             mon_g_a[39:38], mon_g_a[37]);
                end else begin
                    mon_e_a = exp_a.pop_front();
                    if (mon_g_a !== mon_e_a)
                        $display("FAIL dut0_status got code=%0d pstb=%0d idx=%0d data=%h required code=%0d pstb=%0d idx=%0d data=%h",
                                 mon_g_a[39:38], mon_g_a[37], mon_g_a[36:32], mon_g_a[31:0],
                                 mon_e_a[39:38], mon_e_a[37], mon_e_a[36:32], mon_e_a[31:0]);
                    else
                        n_pass++;
                end
            end
            if (sstb[1] || pstb[1]) begin
                mon_g_b = {scode[1], pstb[1], pidx[1], pdat[1]};
                n_checks++;
                if (exp_b.size() == 0) begin
                    $display("FAIL dut1_unexpected_status got code=%0d pstb=%0d required no status",
                             mon_g_b[39:38], mon_g_b[37]);
                end else begin
                    mon_e_b = exp_b.pop_front();
                    if (mon_g_b !== mon_e_b)
                        $display("FAIL dut1_status got code=%0d pstb=%0d idx=%0d data=%h required code=%0d pstb=%0d idx=%0d data=%h",
                                 mon_g_b[39:38], mon_g_b[37], mon_g_b[36:32], mon_g_b[31:0],
                                 mon_e_b[39:38], mon_e_b[37], mon_e_b[36:32], mon_e_b[31:0]);
                    else
                        n_pass++;
                end
            end
        end
    end

    // Reference model: classify a whole packet by its header magic and beat count.
    task automatic model_push(input int sel);
        logic [1:0] code;
        if (pkt_w[0][31:16] != MAGIC) begin
            code = 2'd1;
        end else if (pkt_w.size() != N + 1) begin
            code = 2'd2;
        end else begin
            code = 2'd0;
            held_idx[sel] = pkt_w[0][14:10];
            held_dat[sel] = pkt_w[1];
        end
        if (sel == 0) exp_a.push_back({code, code == 2'd0, held_idx[0], held_dat[0]});
        else          exp_b.push_back({code, code == 2'd0, held_idx[1], held_dat[1]});
    endtask

    task automatic push_missing();
        exp_a.push_back({2'd3, 1'b0, held_idx[0], held_dat[0]});
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ncs   = 1'b0;
        ncs_b = 1'b0;
        for (int d = 0; d < 2; d++) begin
            tv[d] = 1'b0; tl[d] = 1'b0; td[d] = '0;
            held_idx[d] = '0; held_dat[d] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_a.delete();
        exp_b.delete();
    endtask

    task automatic pulse_ncs();
        ncs = 1'b1;
        @(negedge clk);
        ncs = 1'b0;
    endtask

    // Drives pkt_w as beats, holding each until accepted; returns at the negedge after the last beat.
    task automatic send(input int sel, input bit gaps, input bit strobe_on_last, input bit mark_last);
        bit last;
        bit done;
        int waited;
        for (int i = 0; i < pkt_w.size(); i++) begin
            last   = (i == pkt_w.size() - 1);
            done   = 1'b0;
            waited = 0;
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            tv[sel] = 1'b1;
            td[sel] = pkt_w[i];
            tl[sel] = last && mark_last;
            while (!done) begin
                if (strobe_on_last && last && rdy[sel]) ncs = 1'b1;
                done = rdy[sel];
                @(negedge clk);
                ncs = 1'b0;
                waited++;
                if (!done && waited > 200) begin
                    n_checks++;
                    $display("FAIL send_timeout dut=%0d beat=%0d got TREADY=0 for 200 cycles required TREADY=1", sel, i);
                    done = 1'b1;
                end
            end
            tv[sel] = 1'b0;
            tl[sel] = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (sstb[d] !== 1'b0 || scode[d] !== 2'd0 || pstb[d] !== 1'b0)
                $display("FAIL reset_status dut=%0d got sstb=%0d code=%0d pstb=%0d required 0 0 0", d, sstb[d], scode[d], pstb[d]);
            else n_pass++;
            n_checks++;
            if (pidx[d] !== 5'd0 || pdat[d] !== 32'd0)
                $display("FAIL reset_data dut=%0d got idx=%0d data=%h required 0 0", d, pidx[d], pdat[d]);
            else n_pass++;
            n_checks++;
            if (rdy[d] !== 1'b0 || dbg[d] !== 2'd0)
                $display("FAIL reset_ready dut=%0d got tready=%0d state=%0d required 0 0", d, rdy[d], dbg[d]);
            else n_pass++;
        end
    endtask

    task automatic test_good_packet();
        do_reset();
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_0400);
        pkt_w.push_back(32'h1234_5678);
        model_push(0);
        send(0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sstb[0] !== 1'b1 || scode[0] !== 2'd0 || pstb[0] !== 1'b1)
            $display("FAIL good_latency got sstb=%0d code=%0d pstb=%0d required 1 0 1", sstb[0], scode[0], pstb[0]);
        else n_pass++;
        n_checks++;
        if (pidx[0] !== 5'd1 || pdat[0] !== 32'h1234_5678)
            $display("FAIL good_payload got idx=%0d data=%h required 1 12345678", pidx[0], pdat[0]);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (sstb[0] !== 1'b0 || pstb[0] !== 1'b0)
            $display("FAIL good_strobe_width got sstb=%0d pstb=%0d required 0 0", sstb[0], pstb[0]);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0) $display("FAIL good_pending got %0d outstanding required 0", exp_a.size());
        else n_pass++;
    endtask

    task automatic test_bad_magic();
        pkt_w.delete();
        pkt_w.push_back(32'hDEAD_0400);
        pkt_w.push_back($urandom);
        model_push(0);
        send(0, 1'b0, 1'b0, 1'b1);
        pkt_w.delete();
        pkt_w.push_back(32'hDEAD_0800);
        model_push(0);
        send(0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (pidx[0] !== 5'd1 || pdat[0] !== 32'h1234_5678)
            $display("FAIL magic_hold got idx=%0d data=%h required 1 12345678", pidx[0], pdat[0]);
        else n_pass++;
        n_checks++;
        if (exp_a.size() != 0) $display("FAIL magic_pending got %0d outstanding required 0", exp_a.size());
        else n_pass++;
    endtask

    task automatic test_bad_length();
        for (int len = 1; len <= 4; len++) begin
            if (len != N + 1) begin
                pkt_w.delete();
                pkt_w.push_back(32'hB6CF_0800);
                for (int k = 1; k < len; k++) pkt_w.push_back($urandom);
                model_push(0);
                send(0, 1'b0, 1'b0, 1'b1);
            end
        end
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_0C00);
        pkt_w.push_back(32'hCAFE_F00D);
        model_push(0);
        send(0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0) $display("FAIL length_pending got %0d outstanding required 0", exp_a.size());
        else n_pass++;
    endtask

    task automatic test_missing_packet();
        do_reset();
        pulse_ncs();
        repeat (200) @(negedge clk);
        push_missing();
        pulse_ncs();
        repeat (5) @(negedge clk);
        // Last beat on the strobe edge: only the packet status, and it ends that cycle.
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_1400);
        pkt_w.push_back($urandom);
        model_push(0);
        send(0, 1'b0, 1'b1, 1'b1);
        repeat (50) @(negedge clk);
        push_missing();
        pulse_ncs();
        repeat (5) @(negedge clk);
        // Packet straddling a strobe counts toward the following cycle.
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_1800);
        send(0, 1'b0, 1'b0, 1'b0);
        push_missing();
        pulse_ncs();
        pkt_w.push_back($urandom);
        model_push(0);
        void'(pkt_w.pop_front());
        send(0, 1'b0, 1'b0, 1'b1);
        repeat (10) @(negedge clk);
        pulse_ncs();
        repeat (10) @(negedge clk);
        push_missing();
        pulse_ncs();
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0) $display("FAIL missing_pending got %0d outstanding required 0", exp_a.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_0400);
        send(0, 1'b0, 1'b0, 1'b0);
        tv[0] = 1'b1; tl[0] = 1'b1; td[0] = 32'hBAD0_BAD0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tv[0] = 1'b0; tl[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dbg[0] !== 2'd0 || pidx[0] !== 5'd0 || pdat[0] !== 32'd0 || sstb[0] !== 1'b0)
            $display("FAIL midreset_state got state=%0d idx=%0d data=%h sstb=%0d required 0 0 0 0", dbg[0], pidx[0], pdat[0], sstb[0]);
        else n_pass++;
        pkt_w.delete();
        pkt_w.push_back(32'hB6CF_7C00);
        pkt_w.push_back($urandom);
        model_push(0);
        send(0, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0) $display("FAIL midreset_pending got %0d outstanding required 0", exp_a.size());
        else n_pass++;
    endtask

    task automatic test_tready_ratio();
        int hi;
        hi = 0;
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            if (rdy[1]) hi++;
        end
        n_checks++;
        if (hi < 4500 || hi > 5500)
            $display("FAIL tready_ratio got %0d high of 10000 required 4500..5500", hi);
        else n_pass++;
    endtask

    task automatic test_random_backpressure();
        int kind;
        int len;
        logic [15:0] magic;
        do_reset();
        for (int p = 0; p < 30; p++) begin
            kind = $urandom_range(0, 3);
            magic = MAGIC;
            len = N + 1;
            if (kind == 2) begin
                magic = 16'($urandom);
                if (magic == MAGIC) magic = magic ^ 16'h0001;
                len = $urandom_range(1, 3);
            end else if (kind == 3) begin
                len = $urandom_range(0, 2);
                len = (len == 0) ? 1 : len + 2;
            end
            pkt_w.delete();
            pkt_w.push_back({magic, 16'($urandom)});
            for (int k = 1; k < len; k++) pkt_w.push_back($urandom);
            model_push(0);
            send(0, 1'($urandom), 1'b0, 1'b1);
            model_push(1);
            send(1, 1'($urandom), 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL random_pending got %0d/%0d outstanding required 0/0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_magic();
        test_bad_length();
        test_missing_packet();
        test_reset_mid_packet();
        test_tready_ratio();
        test_random_backpressure();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
